// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: constants shared by the fetch sequencer, the instruction
// memory and the main control FSM.
//   - IM_BASE_DEF / PC_RESET_DEF / IM_WORDS_DEF : memory map defaults
//   - NPC_*  : next-PC select encodings driven by the controller
//   - ST_*   : fetch sequencer state encoding
//   - addr_legal() : word-aligned and inside instruction memory
package fetch_ctrl_pkg;

    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam int          IM_WORDS_DEF = 2048;

    localparam logic [1:0] NPC_HOLD   = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // 33-bit compare so a memory ending at the top of the address space
    // cannot wrap the upper bound.
    function automatic logic addr_legal(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int          words);
        logic [32:0] lim;
        lim = {1'b0, base} + (33'(words) << 2);
        return (addr[1:0] == 2'b00) && ({1'b0, addr} >= {1'b0, base})
               && ({1'b0, addr} < lim);
    endfunction

endpackage

// File: rtl/fetch_ctrl_npc.sv
// npc_calc: combinational next-PC target and address legality.
//   pc        in  current PC
//   imm       in  ir[25:0] (branch offset in [15:0], jump index in [25:0])
//   rs_val    in  register value for jump-register
//   npc_sel   in  NPC_* select
//   target    out selected next-PC value
//   target_ok out target is a legal instruction address
//   pc_ok     out current PC is a legal instruction address
module npc_calc
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int          IM_WORDS = IM_WORDS_DEF
) (
    input  logic [31:0] pc,
    input  logic [25:0] imm,
    input  logic [31:0] rs_val,
    input  logic [1:0]  npc_sel,
    output logic [31:0] target,
    output logic        target_ok,
    output logic        pc_ok
);

    always_comb begin
        target = pc;
        case (npc_sel)
            NPC_BRANCH: target = pc + {{14{imm[15]}}, imm[15:0], 2'b00};
            NPC_JUMP:   target = {pc[31:28], imm, 2'b00};
            NPC_JR:     target = rs_val;
            default:    target = pc;
        endcase
    end

    assign target_ok = addr_legal(target, IM_BASE, IM_WORDS);
    assign pc_ok     = addr_legal(pc, IM_BASE, IM_WORDS);

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns pc and ir, drives the
// instruction memory address and handshakes fetches with the control FSM.
//   clk, reset           clock, async active-high reset
//   fetch_req/fetch_done level request in, one-cycle completion pulse out
//   im_pc/im_instr       instruction memory address out, data in
//   ir, pc               instruction register, program counter
//   pc_wr/npc_sel/rs_val next-PC update (taken only in IDLE)
//   fault                sticky illegal-address flag; blocks further fetches
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET    = PC_RESET_DEF,
    parameter logic [31:0] IM_BASE     = IM_BASE_DEF,
    parameter int          IM_WORDS    = IM_WORDS_DEF,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    output logic        fetch_done,
    output logic [31:0] im_pc,
    input  logic [31:0] im_instr,
    output logic [31:0] ir,
    output logic [31:0] pc,
    input  logic        pc_wr,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] rs_val,
    output logic        fault
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   target;
    logic          target_ok;
    logic          pc_ok;
    logic          last_wait;

    npc_calc #(
        .IM_BASE  (IM_BASE),
        .IM_WORDS (IM_WORDS)
    ) u_npc (
        .pc        (pc),
        .imm       (ir[25:0]),
        .rs_val    (rs_val),
        .npc_sel   (npc_sel),
        .target    (target),
        .target_ok (target_ok),
        .pc_ok     (pc_ok)
    );

    assign im_pc     = pc;
    assign last_wait = (cnt == CW'(WAIT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            pc         <= PC_RESET;
            ir         <= '0;
            fetch_done <= 1'b0;
            fault      <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A pc update wins the cycle; a concurrent request is
                    // served next cycle from the new pc.
                    if (pc_wr) begin
                        if (npc_sel != NPC_HOLD) begin
                            if (target_ok) pc    <= target;
                            else           fault <= 1'b1;
                        end
                    end else if (fetch_req && !fault) begin
                        if (pc_ok) begin
                            state <= ST_FETCH;
                            cnt   <= '0;
                        end else begin
                            fault <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (last_wait) begin
                        ir         <= im_instr;
                        pc         <= pc + 32'd4;
                        fetch_done <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam logic [31:0] PCRST = 32'h0000_3000;
    localparam int          WORDS = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        fetch_req = 1'b0, pc_wr = 1'b0;
    logic [1:0]  npc_sel = 2'b00;
    logic [31:0] rs_val = '0;
    logic        fetch_done, fault;
    logic [31:0] im_pc, im_instr, ir, pc;

    // second instance with a slow memory, used for the latency check only
    logic        fetch_req_w2 = 1'b0, pc_wr_w2 = 1'b0;
    logic        fetch_done_w2, fault_w2;
    logic [31:0] im_pc_w2, im_instr_w2, ir_w2, pc_w2;

    logic [31:0] mem [0:WORDS-1];

    int n_chk = 0, n_fail = 0;

    // reference model state (transaction level)
    logic [31:0] m_pc, m_ir;
    bit          m_fault;

    fetch_ctrl #(.PC_RESET(PCRST), .IM_BASE(BASE), .IM_WORDS(WORDS), .WAIT_CYCLES(0)) u_dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_done(fetch_done),
        .im_pc(im_pc), .im_instr(im_instr), .ir(ir), .pc(pc), .pc_wr(pc_wr),
        .npc_sel(npc_sel), .rs_val(rs_val), .fault(fault));

    fetch_ctrl #(.PC_RESET(PCRST), .IM_BASE(BASE), .IM_WORDS(WORDS), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .reset(reset), .fetch_req(fetch_req_w2), .fetch_done(fetch_done_w2),
        .im_pc(im_pc_w2), .im_instr(im_instr_w2), .ir(ir_w2), .pc(pc_w2), .pc_wr(pc_wr_w2),
        .npc_sel(npc_sel), .rs_val(rs_val), .fault(fault_w2));

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a >= BASE) && (a < BASE + 4 * WORDS);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (legal(a)) return mem[off[12:2]];
        return 32'hdead_beef;
    endfunction

    assign im_instr    = mem_rd(im_pc);
    assign im_instr_w2 = mem_rd(im_pc_w2);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_pc"}, pc, m_pc);
        chk({tag, "_ir"}, ir, m_ir);
        chk({tag, "_fault"}, 32'(fault), 32'(m_fault));
    endtask

    function automatic logic [31:0] model_target(input logic [1:0] sel, input logic [31:0] rs);
        int off;
        case (sel)
            2'b01: begin
                off = int'($signed(m_ir[15:0]));
                return m_pc + 32'(off * 4);
            end
            2'b10: return {m_pc[31:28], m_ir[25:0], 2'b00};
            2'b11: return rs;
            default: return m_pc;
        endcase
    endfunction

    // all tasks start and end at a falling edge
    task automatic do_reset();
        reset = 1'b1; fetch_req = 1'b0; pc_wr = 1'b0; fetch_req_w2 = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        m_pc = PCRST; m_ir = '0; m_fault = 1'b0;
        check_state("reset");
        chk("reset_done", 32'(fetch_done), 32'd0);
    endtask

    task automatic do_fetch();
        bit ok, seen;
        int n;
        logic [31:0] exp_ir;
        ok = !m_fault && legal(m_pc);
        exp_ir = mem_rd(m_pc);
        seen = 1'b0; n = 0;
        fetch_req = 1'b1;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(posedge clk); @(negedge clk);
            n = i + 1;
            if (fetch_done) seen = 1'b1;
        end
        fetch_req = 1'b0;
        if (ok) begin
            chk("fetch_seen", 32'(seen), 32'd1);
            chk("fetch_lat", 32'(n), 32'd2);
            m_ir = exp_ir;
            m_pc = m_pc + 32'd4;
        end else begin
            chk("blocked_done", 32'(seen), 32'd0);
            m_fault = 1'b1;
        end
        check_state("fetch");
        @(posedge clk); @(negedge clk);
        chk("done_pulse", 32'(fetch_done), 32'd0);
    endtask

    task automatic do_pcwr(input logic [1:0] sel, input logic [31:0] rs, input bit with_req);
        logic [31:0] t;
        pc_wr = 1'b1; npc_sel = sel; rs_val = rs; fetch_req = with_req;
        @(posedge clk); @(negedge clk);
        pc_wr = 1'b0; rs_val = $urandom;
        chk("pcwr_done", 32'(fetch_done), 32'd0);
        if (sel != 2'b00) begin
            t = model_target(sel, rs);
            if (legal(t)) m_pc = t;
            else          m_fault = 1'b1;
        end
        check_state("pcwr");
        if (with_req) do_fetch();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int n;
        logic [31:0] exp_ir;

        for (int i = 0; i < WORDS; i++) begin
            case ($urandom_range(0, 3))
                0: mem[i] = {6'h04, 10'h000, 16'($urandom_range(0, 40) - 20)};
                1: mem[i] = {6'h02, 26'(32'h0C00 + $urandom_range(0, 2100))};
                default: mem[i] = $urandom;
            endcase
        end
        mem[0] = 32'h3c01_0001;
        mem[1] = 32'h1000_fffe;
        mem[2] = 32'h0800_0c10;

        @(negedge clk);
        do_reset();

        // slow memory: done on the 4th edge, ir untouched before then
        seen = 1'b0; n = 0;
        fetch_req_w2 = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk); @(negedge clk);
            n = i + 1;
            if (fetch_done_w2) seen = 1'b1;
            else chk("w2_ir_hold", ir_w2, 32'd0);
        end
        fetch_req_w2 = 1'b0;
        chk("w2_lat", 32'(n), 32'd4);
        chk("w2_ir", ir_w2, 32'h3c01_0001);
        chk("w2_pc", pc_w2, 32'h0000_3004);
        @(posedge clk); @(negedge clk);
        chk("w2_pulse", 32'(fetch_done_w2), 32'd0);

        // first fetch, branch back, jump
        do_fetch();
        chk("plan_ir0", ir, 32'h3c01_0001);
        chk("plan_pc0", pc, 32'h0000_3004);
        do_fetch();
        do_pcwr(2'b01, 32'h0, 1'b0);
        chk("plan_branch", pc, 32'h0000_3000);
        do_pcwr(2'b11, 32'h0000_3008, 1'b0);
        do_fetch();
        do_pcwr(2'b10, 32'h0, 1'b0);
        chk("plan_jump", pc, 32'h0000_3040);

        // pc_wr while in FETCH is ignored
        exp_ir = mem_rd(m_pc);
        fetch_req = 1'b1;
        @(posedge clk); @(negedge clk);
        pc_wr = 1'b1; npc_sel = 2'b11; rs_val = BASE + 32'h100;
        @(posedge clk); @(negedge clk);
        pc_wr = 1'b0; fetch_req = 1'b0;
        chk("fetchwr_done", 32'(fetch_done), 32'd1);
        m_ir = exp_ir; m_pc = m_pc + 32'd4;
        check_state("fetchwr");
        @(posedge clk); @(negedge clk);

        // pc_wr together with fetch_req
        do_pcwr(2'b11, 32'h0000_3000, 1'b1);
        chk("wrreq_ir", ir, 32'h3c01_0001);

        // misaligned jr faults and blocks fetches
        do_pcwr(2'b11, 32'h0000_3002, 1'b0);
        chk("plan_jr_fault", 32'(fault), 32'd1);
        do_fetch();
        do_reset();
        do_pcwr(2'b11, 32'h0000_5000, 1'b0);
        chk("plan_jr_end", 32'(fault), 32'd1);
        do_reset();

        // last word: increment runs past the end, next request faults
        do_pcwr(2'b11, 32'h0000_4ffc, 1'b0);
        do_fetch();
        chk("end_pc", pc, 32'h0000_5000);
        do_fetch();
        chk("end_fault", 32'(fault), 32'd1);
        do_reset();

        // reset in the middle of a fetch
        do_fetch();
        fetch_req = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_pc", pc, PCRST);
        chk("midrst_ir", ir, 32'd0);
        chk("midrst_fault", 32'(fault), 32'd0);
        chk("midrst_done", 32'(fetch_done), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("midrst_done2", 32'(fetch_done), 32'd0);
        fetch_req = 1'b0; reset = 1'b0;
        m_pc = PCRST; m_ir = '0; m_fault = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("midrst_done3", 32'(fetch_done), 32'd0);
        check_state("midrst");

        // randomized transactions against the model
        for (int k = 0; k < 300; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (m_fault && $urandom_range(0, 2) == 0) do_reset();
            else if (r < 4) do_fetch();
            else if (r == 4) do_pcwr(2'b01, 32'h0, $urandom_range(0, 1) == 1);
            else if (r == 5) do_pcwr(2'b10, 32'h0, $urandom_range(0, 1) == 1);
            else if (r == 6) do_pcwr(2'b11, BASE + 4 * $urandom_range(0, WORDS - 1), $urandom_range(0, 1) == 1);
            else if (r == 7) do_pcwr(2'b11, $urandom_range(0, 1) == 1 ? $urandom : BASE + 4 * $urandom_range(0, 20) + 1, 1'b0);
            else if (r == 8) do_pcwr(2'b00, $urandom, $urandom_range(0, 1) == 1);
            else do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the multi-cycle MIPS core. Owns the program counter and the instruction register, drives the word-addressed instruction memory (base 0x00003000, 2048 words), and runs a fetch handshake with the main control FSM. Also applies the next-PC update selected by the controller and flags any illegal target address.

## Interface
- PC_RESET, 32'h00003000, PC value after reset
- IM_BASE, 32'h00003000, byte address of instruction memory word 0
- IM_WORDS, 2048, instruction memory depth in words
- WAIT_CYCLES, 0, extra instruction-memory read cycles (0 = combinational read)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- fetch_req  in  1  level request from control FSM; held until fetch_done
- fetch_done  out  1  one-cycle pulse: IR and PC updated
- im_pc  out  32  byte address to instruction memory (current PC)
- im_instr  in  32  instruction word returned by memory
- ir  out  32  instruction register
- pc  out  32  current PC (= address of ir + 4 after a fetch; jal link value)
- pc_wr  in  1  apply next-PC selection this cycle
- npc_sel  in  2  00 hold, 01 branch, 10 jump, 11 jump-register
- rs_val  in  32  register value for jr
- fault  out  1  sticky illegal-address flag

## Operation
- States: IDLE, FETCH, DONE. Reset: state IDLE, pc=PC_RESET, ir=0, fetch_done=0, fault=0, wait counter 0.
- im_pc = pc at all times.
- IDLE: fetch_req=1 and pc_wr=0 and fault=0 and pc legal -> FETCH, counter cleared. fetch_req with illegal pc -> fault set, stay IDLE, no fetch_done.
- FETCH: counter increments each cycle; when counter == WAIT_CYCLES: ir<=im_instr, pc<=pc+4, -> DONE.
- DONE: fetch_done=1 for this one cycle; -> IDLE unconditionally. Controller must drop fetch_req on seeing fetch_done; a still-high request starts a new fetch from IDLE the next cycle.
- Next-PC (pc_wr=1, state IDLE only), using ir and current pc:
  - 00: pc unchanged.
  - 01: target = pc + (sign_extend(ir[15:0]) << 2), 32-bit wrap.
  - 10: target = {pc[31:28], ir[25:0], 2'b00}.
  - 11: target = rs_val.
- Legal address: addr[1:0]==0 and IM_BASE <= addr < IM_BASE + 4*IM_WORDS. Illegal target -> pc unchanged, fault set.
- fault is sticky until reset; while set, no further fetches start.
- pc_wr in FETCH or DONE: ignored (pc unchanged, no fault).
- pc_wr and fetch_req both high in IDLE: pc update takes effect; fetch starts next cycle from new pc.
- pc+4 past last word is not checked at increment; the next fetch_req flags it.

## Timing
- WAIT_CYCLES=0: fetch_req sampled at edge t -> FETCH; edge t+1 loads ir/pc -> DONE; fetch_done high during cycle t+1..t+2. Request-to-done = WAIT_CYCLES+2 edges.
- ir and pc change only at the FETCH->DONE edge or the pc_wr edge.
- fault rises at the edge sampling the illegal request/target.
- reset mid-fetch: aborts immediately; ir=0, pc=PC_RESET, fetch_done low within the reset cycle.
- All outputs registered except im_pc (= pc, registered source).

## Structure
- Shared package: npc_sel encodings (NPC_HOLD, NPC_BRANCH, NPC_JUMP, NPC_JR), state encoding, IM_BASE / PC_RESET constants shared with the memory and the control FSM.
- One sub-module natural: npc_calc (combinational target computation + legality check), instantiated once.

## Test plan
- Reset then fetch_req, memory word0=0x3c010001: fetch_done at 2nd edge, ir=0x3c010001, pc=0x00003004.
- WAIT_CYCLES=2: fetch_done on 4th edge after request; ir unchanged until then.
- Branch: ir=0x1000fffe, pc=0x00003008, pc_wr npc_sel=01 -> pc=0x00003000; jump ir=0x08000c10 -> pc=0x00003040.
- jr rs_val=0x00003002 -> fault=1, pc unchanged, subsequent fetch_req gives no fetch_done; jr 0x00005000 (past end) -> fault.
- pc_wr during FETCH ignored; pc_wr+fetch_req together in IDLE fetches from new target.
- reset asserted mid-FETCH -> pc=0x00003000, ir=0, fault=0, no fetch_done pulse.
